// File: rtl/pipe_skid32_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid32_if
// Brief    : Valid/ready handshake bundle for the 32-bit skid pipeline.
// Revision : 1.0
// ============================================================================
interface pipe_skid32_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  // Driven by the pipeline itself.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  // Driven by the surrounding upstream/downstream logic.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid32.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid32
// Brief    : 2-entry elastic pipeline register (head + skid) with flush and
//            a wrapping count of completed output transfers.
// Revision : 1.0
// ============================================================================
module pipe_skid32 (
  input  wire          Clk,
  input  wire          Rst,
  input  wire          Flush,
  pipe_skid32_if.slave bus,
  output logic [1:0]   Occupancy,
  output logic [15:0]  Xfer_count
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // Declaration initialisers give the reset values at power-up as well.
  logic [1:0]  r_state      = S_EMPTY;
  logic [31:0] r_main       = 32'h0000_0000;
  logic [31:0] r_skid       = 32'h0000_0000;
  logic [15:0] r_xfer_count = 16'h0000;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [1:0]  w_occupancy;
  logic        w_accept;
  logic        w_pop;

  // Handshake flags come only from the state register, so in_ready never
  // depends combinationally on out_ready.
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    w_occupancy = 2'd0;
    case (r_state)
      S_EMPTY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
      end
      S_ONE: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
        w_occupancy = 2'd1;
      end
      S_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        w_occupancy = 2'd2;
      end
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
      end
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_pop    = w_out_valid & bus.out_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_EMPTY;
      r_main       <= 32'h0000_0000;
      r_skid       <= 32'h0000_0000;
      r_xfer_count <= 16'h0000;
    end else begin
      // A pop in a flush cycle still completed downstream, so it is counted.
      if (w_pop) begin
        r_xfer_count <= r_xfer_count + 16'd1;
      end
      if (Flush) begin
        r_state <= S_EMPTY;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_accept) begin
              r_state <= S_ONE;
              r_main  <= bus.in_data;
            end
          end
          S_ONE: begin
            if (w_accept && !w_pop) begin
              r_state <= S_FULL;
              r_skid  <= bus.in_data;
            end else if (w_accept && w_pop) begin
              r_main  <= bus.in_data;
            end else if (w_pop) begin
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_pop) begin
              r_state <= S_ONE;
              r_main  <= r_skid;
            end
          end
          default: begin
            r_state <= S_EMPTY;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign Occupancy     = w_occupancy;
  assign Xfer_count    = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid32.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid32
// Brief    : Directed self-checking bench for pipe_skid32.
// Revision : 1.0
// ============================================================================
module tb_pipe_skid32;

  logic        Clk   = 1'b0;
  logic        Rst   = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  Occupancy;
  logic [15:0] Xfer_count;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_xfer = 16'h0000;

  pipe_skid32_if u_if ();

  pipe_skid32 dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Flush      (Flush),
    .bus        (u_if.slave),
    .Occupancy  (Occupancy),
    .Xfer_count (Xfer_count)
  );

  always #5 Clk = ~Clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    u_if.in_valid  = 1'b0;
    u_if.in_data   = 32'h0;
    u_if.out_ready = 1'b0;
    #1;
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL powerup_occ: got %0d expected 0", Occupancy); end
    checks++; if (Xfer_count !== 16'h0) begin errors++; $display("FAIL powerup_xfer: got %h expected 0000", Xfer_count); end
    checks++; if (u_if.out_data !== 32'h0) begin errors++; $display("FAIL powerup_data: got %h expected 00000000", u_if.out_data); end
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", u_if.out_valid); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", u_if.in_ready); end
    checks++; if (u_if.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", u_if.out_data); end
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", Occupancy); end
    checks++; if (Xfer_count !== 16'h0) begin errors++; $display("FAIL reset_xfer: got %h expected 0000", Xfer_count); end
    exp_xfer = 16'h0000;
  endtask

  task automatic test_pass_through();
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      u_if.in_data = 32'(k);
      tick();
      checks++; if (u_if.out_data !== 32'(k)) begin errors++; $display("FAIL pass_data[%0d]: got %h expected %h", k, u_if.out_data, 32'(k)); end
      checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid[%0d]: got %b expected 1", k, u_if.out_valid); end
      checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready[%0d]: got %b expected 1", k, u_if.in_ready); end
    end
    u_if.in_valid = 1'b0;
    tick();
    exp_xfer = exp_xfer + 16'd8;
    checks++; if (Xfer_count !== exp_xfer) begin errors++; $display("FAIL pass_xfer: got %h expected %h", Xfer_count, exp_xfer); end
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL pass_occ_end: got %0d expected 0", Occupancy); end
  endtask

  task automatic test_backpressure();
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 32'hAAAA0001;
    tick();
    checks++; if (Occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1: got %0d expected 1", Occupancy); end
    u_if.in_data = 32'hAAAA0002;
    tick();
    checks++; if (Occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2: got %0d expected 2", Occupancy); end
    checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", u_if.in_ready); end
    u_if.in_data = 32'hAAAA0003;
    tick();
    checks++; if (Occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold_occ: got %0d expected 2", Occupancy); end
    checks++; if (u_if.out_data !== 32'hAAAA0001) begin errors++; $display("FAIL bp_hold_data: got %h expected AAAA0001", u_if.out_data); end
    u_if.out_ready = 1'b1;
    tick();
    checks++; if (u_if.out_data !== 32'hAAAA0002) begin errors++; $display("FAIL bp_second: got %h expected AAAA0002", u_if.out_data); end
    checks++; if (Occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_after_pop: got %0d expected 1", Occupancy); end
    tick();
    checks++; if (u_if.out_data !== 32'hAAAA0003) begin errors++; $display("FAIL bp_third: got %h expected AAAA0003", u_if.out_data); end
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_third_valid: got %b expected 1", u_if.out_valid); end
    u_if.in_valid = 1'b0;
    tick();
    exp_xfer = exp_xfer + 16'd3;
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL bp_drain_occ: got %0d expected 0", Occupancy); end
    checks++; if (Xfer_count !== exp_xfer) begin errors++; $display("FAIL bp_xfer: got %h expected %h", Xfer_count, exp_xfer); end
  endtask

  task automatic test_simultaneous();
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 32'h11111111;
    tick();
    checks++; if (u_if.out_data !== 32'h11111111) begin errors++; $display("FAIL sim_first: got %h expected 11111111", u_if.out_data); end
    u_if.out_ready = 1'b1;
    u_if.in_data   = 32'h22222222;
    tick();
    checks++; if (u_if.out_data !== 32'h22222222) begin errors++; $display("FAIL sim_data: got %h expected 22222222", u_if.out_data); end
    checks++; if (Occupancy !== 2'd1) begin errors++; $display("FAIL sim_occ: got %0d expected 1", Occupancy); end
    u_if.in_valid = 1'b0;
    tick();
    exp_xfer = exp_xfer + 16'd2;
    checks++; if (Xfer_count !== exp_xfer) begin errors++; $display("FAIL sim_xfer: got %h expected %h", Xfer_count, exp_xfer); end
  endtask

  task automatic test_flush();
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 32'hCAFE0001;
    tick();
    u_if.in_data = 32'hCAFE0002;
    tick();
    checks++; if (Occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 2", Occupancy); end
    Flush          = 1'b1;
    u_if.out_ready = 1'b1;
    u_if.in_data   = 32'hDEADBEEF;
    tick();
    Flush         = 1'b0;
    u_if.in_valid = 1'b0;
    exp_xfer = exp_xfer + 16'd1;
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", Occupancy); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", u_if.out_valid); end
    checks++; if (Xfer_count !== exp_xfer) begin errors++; $display("FAIL flush_xfer: got %h expected %h", Xfer_count, exp_xfer); end
    checks++; if (u_if.out_data !== 32'hCAFE0001) begin errors++; $display("FAIL flush_main_kept: got %h expected CAFE0001", u_if.out_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid[%0d]: got %b expected 0", k, u_if.out_valid); end
    end
    u_if.in_valid = 1'b1;
    u_if.in_data  = 32'h00000005;
    tick();
    u_if.in_valid = 1'b0;
    checks++; if (u_if.out_data !== 32'h00000005) begin errors++; $display("FAIL flush_next_word: got %h expected 00000005", u_if.out_data); end
    tick();
    exp_xfer = exp_xfer + 16'd1;
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL flush_drain_occ: got %0d expected 0", Occupancy); end
  endtask

  task automatic test_wrap();
    int n;
    n = 65535 - int'(exp_xfer);
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 32'h12345678;
    repeat (n) tick();
    u_if.in_valid = 1'b0;
    tick();
    checks++; if (Xfer_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected FFFF", Xfer_count); end
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    tick();
    checks++; if (Xfer_count !== 16'h0000) begin errors++; $display("FAIL wrap_rollover: got %h expected 0000", Xfer_count); end
    exp_xfer = 16'h0000;
  endtask

  task automatic test_reset_full();
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 32'hBBBB0001;
    tick();
    u_if.in_data = 32'hBBBB0002;
    tick();
    checks++; if (Occupancy !== 2'd2) begin errors++; $display("FAIL rstfull_pre_occ: got %0d expected 2", Occupancy); end
    Rst            = 1'b1;
    u_if.out_ready = 1'b1;
    tick();
    Rst           = 1'b0;
    u_if.in_valid = 1'b0;
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_valid: got %b expected 0", u_if.out_valid); end
    checks++; if (u_if.out_data !== 32'h0) begin errors++; $display("FAIL rstfull_data: got %h expected 00000000", u_if.out_data); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_ready: got %b expected 1", u_if.in_ready); end
    checks++; if (Xfer_count !== 16'h0) begin errors++; $display("FAIL rstfull_xfer: got %h expected 0000", Xfer_count); end
    checks++; if (Occupancy !== 2'd0) begin errors++; $display("FAIL rstfull_occ: got %0d expected 0", Occupancy); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid32.md
PIPE_SKID32 -- requirements
Module: pipe_skid32

Interface
REQ-001 Clk  input  1  rising-edge clock, sole clock domain.
REQ-002 Rst  input  1  reset; synchronous, active-high, sampled on rising edge of Clk.
REQ-003 Flush  input  1  discard all buffered words; synchronous, active-high.
REQ-004 in_valid  input  1  upstream word present on in_data.
REQ-005 in_data  input  32  upstream data word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_valid  output  1  word present on out_data.
REQ-008 out_data  output  32  downstream data word (head of buffer).
REQ-009 out_ready  input  1  downstream consumes word this cycle.
REQ-010 Occupancy  output  2  number of words held (0..2).
REQ-011 Xfer_count  output  16  count of completed output transfers.

Function
REQ-012 Block SHALL be a 2-entry elastic pipeline register: main register (head) plus skid register, states EMPTY, ONE, FULL.
REQ-013 Input accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; output pop where out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; derived only from state registers, no combinational path from out_ready.
REQ-015 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; out_data SHALL be the main register, held stable while out_valid=1 and out_ready=0.
REQ-016 Occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL.
REQ-017 EMPTY: accept -> ONE, main<=in_data; else stay.
REQ-018 ONE: accept and no pop -> FULL, skid<=in_data; pop and no accept -> EMPTY; accept and pop simultaneously -> ONE, main<=in_data; neither -> stay.
REQ-019 FULL: pop -> ONE, main<=skid; no pop -> stay; no accept possible.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge N appears on out_data with out_valid=1 after edge N when buffer was EMPTY or when popped simultaneously in ONE.
REQ-021 Ordering SHALL be strict FIFO; no word duplicated or lost except by Flush/Rst.
REQ-022 Flush=1 SHALL force EMPTY at the next edge, discarding held words and any word offered that cycle; a pop in the same cycle SHALL still count in Xfer_count.
REQ-023 Xfer_count SHALL increment by 1 on every pop, wrapping 0xFFFF -> 0x0000; Flush SHALL NOT clear it.
REQ-024 Main and skid data registers SHALL be unchanged by Flush (only state cleared).

Reset
REQ-025 Rst SHALL take priority over Flush and all handshakes.
REQ-026 On Rst: state EMPTY, main=0, skid=0, Xfer_count=0; hence out_valid=0, out_data=0x00000000, in_ready=1, Occupancy=0 from the edge after Rst.
REQ-027 Rst asserted mid-operation (ONE or FULL) SHALL discard held words with no pop counted that cycle.
REQ-028 Registers SHALL also initialise to the reset values at power-up.

Verification
REQ-029 Pass-through: out_ready=1, in_valid=1 with 0x00000001..0x00000008 on consecutive cycles -> same sequence on out_data one cycle later, in_ready stays 1, Xfer_count=8.
REQ-030 Backpressure: out_ready=0, push 0xAAAA0001 then 0xAAAA0002 -> Occupancy=2, in_ready=0, 0xAAAA0003 held upstream; release out_ready -> out_data 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 in order.
REQ-031 Simultaneous accept+pop in ONE holding 0x11111111, input 0x22222222 -> next cycle out_data=0x22222222, Occupancy=1.
REQ-032 Flush in FULL with in_valid=1 offering 0xDEADBEEF and out_ready=1 -> next cycle Occupancy=0, out_valid=0, Xfer_count incremented by 1, 0xDEADBEEF never appears.
REQ-033 Counter wrap: preload via 65535 pops, one more pop -> Xfer_count=0x0000.
REQ-034 Rst in FULL with out_ready=1 -> next cycle out_valid=0, out_data=0x00000000, in_ready=1, Xfer_count=0.
